// File: rtl/gf_mulred_seq_if.sv
// gf_mulred_seq_if: request/response and shared-unit signals of gf_mulred_seq
interface gf_mulred_seq_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int WW = $clog2(DATA_WIDTH) + 1;
    logic                    req_valid;
    logic                    req_ready;
    logic [DATA_WIDTH-1:0]   req_a;
    logic [DATA_WIDTH-1:0]   req_b;
    logic [WW-1:0]           req_width;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_result;
    logic                    rsp_error;
    logic                    op_enable;
    logic                    op_finish;
    logic                    sum_funct;
    logic                    exp_funct;
    logic                    red_funct;
    logic                    carry_option;
    logic [WW-1:0]           in_width;
    logic [DATA_WIDTH-1:0]   in_a;
    logic [DATA_WIDTH-1:0]   in_b;
    logic [DATA_WIDTH:0]     polyn_red_in;
    logic [2*DATA_WIDTH-1:0] reduc_in;
    logic [2*DATA_WIDTH-1:0] out_mult;
    logic [DATA_WIDTH-1:0]   out_poly;
    modport master (
        output req_valid, req_a, req_b, req_width, rsp_ready, op_finish, out_mult, out_poly,
        input  req_ready, rsp_valid, rsp_result, rsp_error, op_enable, sum_funct, exp_funct,
               red_funct, carry_option, in_width, in_a, in_b, polyn_red_in, reduc_in
    );
    modport slave (
        input  req_valid, req_a, req_b, req_width, rsp_ready, op_finish, out_mult, out_poly,
        output req_ready, rsp_valid, rsp_result, rsp_error, op_enable, sum_funct, exp_funct,
               red_funct, carry_option, in_width, in_a, in_b, polyn_red_in, reduc_in
    );
endinterface

// File: rtl/gf_mulred_seq.sv
// gf_mulred_seq: GF(2^m) multiply sequenced as carry-less multiply then reduction on a shared unit
module gf_mulred_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_GF     = 16,
    parameter int TIMEOUT    = 256
) (
    input logic            clk,
    input logic            rst_n,
    gf_mulred_seq_if.slave bus
);
    localparam int WW = $clog2(DATA_WIDTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, MUL, GAP, RED, DONE} state_t;
    state_t                  state, state_nx;
    logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
    logic [WW-1:0]           m_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic                    err_q;
    logic [CW-1:0]           wd_q;
    logic                    req_ok, wd_exp, busy;

    function automatic logic [DATA_WIDTH-1:0] mask_of(input logic [WW-1:0] m);
        return (DATA_WIDTH'(1) << m) - DATA_WIDTH'(1);
    endfunction

    function automatic logic [16:0] irr_poly(input logic [WW-1:0] m);
        case (int'(m))
            2:       return 17'd7;
            3:       return 17'd11;
            4:       return 17'd19;
            5:       return 17'd37;
            6:       return 17'd67;
            7:       return 17'd137;
            8:       return 17'd285;
            9:       return 17'd529;
            10:      return 17'd1033;
            11:      return 17'd2053;
            12:      return 17'd4179;
            13:      return 17'd8219;
            14:      return 17'd17475;
            15:      return 17'd32771;
            16:      return 17'd69643;
            default: return 17'd0;
        endcase
    endfunction

    assign req_ok = bus.req_width >= WW'(2) && int'(bus.req_width) <= MAX_GF;
    assign wd_exp = wd_q == CW'(TIMEOUT - 1);
    assign busy   = state == MUL || state == RED;

    // next state and Moore outputs; the shared unit sees zeros whenever op_enable is low
    always_comb begin
        state_nx         = state;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_result   = '0;
        bus.rsp_error    = 1'b0;
        bus.op_enable    = 1'b0;
        bus.sum_funct    = 1'b0;
        bus.exp_funct    = 1'b0;
        bus.red_funct    = 1'b0;
        bus.carry_option = 1'b0;
        bus.in_width     = '0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.polyn_red_in = '0;
        bus.reduc_in     = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                state_nx      = bus.req_valid ? (req_ok ? MUL : DONE) : IDLE;
            end
            MUL: begin
                bus.op_enable = 1'b1;
                bus.in_width  = m_q;
                bus.in_a      = a_q;
                bus.in_b      = b_q;
                state_nx      = bus.op_finish ? GAP : (wd_exp ? DONE : MUL);
            end
            GAP: state_nx = RED;
            RED: begin
                bus.op_enable    = 1'b1;
                bus.red_funct    = 1'b1;
                bus.in_width     = m_q;
                bus.polyn_red_in = (DATA_WIDTH + 1)'(irr_poly(m_q));
                bus.reduc_in     = prod_q;
                state_nx         = (bus.op_finish || wd_exp) ? DONE : RED;
            end
            DONE: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = res_q;
                bus.rsp_error  = err_q;
                state_nx       = bus.rsp_ready ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, captured operands, product/result registers and per-phase watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            prod_q <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            wd_q   <= '0;
        end else begin
            state <= state_nx;
            wd_q  <= (busy && state_nx == state) ? wd_q + CW'(1) : '0;
            if (state == IDLE && bus.req_valid) begin
                a_q   <= bus.req_a & mask_of(bus.req_width);
                b_q   <= bus.req_b & mask_of(bus.req_width);
                m_q   <= bus.req_width;
                res_q <= '0;
                err_q <= !req_ok;
            end
            if (state == MUL && bus.op_finish) prod_q <= bus.out_mult;
            if (state == RED && bus.op_finish) begin
                res_q <= bus.out_poly & mask_of(m_q);
                err_q <= 1'b0;
            end else if (busy && !bus.op_finish && wd_exp) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end
endmodule
